// File: rtl/ifu.sv
// ifu: instruction fetch unit, one outstanding imem read, valid/ready delivery to decode.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_fault
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, HALTED} state_t;
  state_t state;
  logic [31:0] pc;
  logic kill;
  logic redir;
  assign imem_req_valid = state == REQ && !halt;
  assign out_valid = state == HOLD;
  assign imem_req_addr = pc;
  assign redir = redirect_valid && (state == REQ || state == WAIT || state == HOLD);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      pc <= RESET_PC;
      kill <= 1'b0;
      fetch_fault <= 1'b0;
      out_inst <= '0;
      out_pc <= '0;
    end else if (redir && redirect_pc[1:0] != 2'b00) begin
      fetch_fault <= 1'b1;
      state <= HALTED;
    end else if (redir) begin
      pc <= redirect_pc;
      case (state)
        REQ: if (imem_req_valid && imem_req_ready) begin
          state <= WAIT;
          kill <= 1'b1;
        end
        // a response landing with the redirect is dropped right here
        WAIT: if (imem_rsp_valid) begin
          state <= REQ;
          kill <= 1'b0;
        end else kill <= 1'b1;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: state <= halt ? HALTED : imem_req_ready ? WAIT : REQ;
        WAIT: if (imem_rsp_valid) begin
          kill <= 1'b0;
          state <= kill ? REQ : HOLD;
          if (!kill) begin
            out_inst <= imem_rsp_data;
            out_pc <= pc;
          end
        end
        HOLD: if (out_ready) begin
          pc <= pc + 32'd4;
          state <= REQ;
        end
        default: state <= HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed and random checks of ifu against a fetch-stream model and a simple memory.
module tb_ifu;
  localparam logic [31:0] RST = 32'h8000_0000;
  logic clk = 0, rst_n = 0;
  logic imem_req_ready = 1, imem_rsp_valid = 0, out_ready = 0, redirect_valid = 0, halt = 0;
  logic [31:0] imem_rsp_data = 0, redirect_pc = 0;
  logic imem_req_valid, out_valid, fetch_fault;
  logic [31:0] imem_req_addr, out_inst, out_pc;

  ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0, n_deliv = 0;
  logic [31:0] exp_pc = RST;
  bit m_halt = 0, m_fault = 0;
  bit pend = 0, rnd = 0, bad_data = 0, saw_dead = 0;
  logic [31:0] pend_addr = 0;
  int wait_cnt = 0, max_wait = 0;
  logic s_ov, s_rv;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'h8000_0000 ? 32'h00100093 :
           a == 32'h8000_0004 ? 32'h00100073 : {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance model at the edge, drive memory at negedge.
  task automatic tick();
    logic fire_req, fire_out, rsp_now;
    logic [31:0] a;
    #1;
    s_ov = out_valid; s_rv = imem_req_valid; s_addr = imem_req_addr; s_pc = out_pc; s_inst = out_inst;
    if (rst_n) begin
      chk("fetch_fault", fetch_fault, m_fault);
      if (m_halt) begin
        chk("halted_req_valid", imem_req_valid, 0);
        chk("halted_out_valid", out_valid, 0);
      end else begin
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
        if (out_valid) begin
          chk("out_pc", out_pc, exp_pc);
          chk("out_inst", out_inst, word(exp_pc));
        end
        chk("req_and_out", imem_req_valid & out_valid, 0);
      end
      if (out_valid && out_inst == 32'hDEADBEEF) saw_dead = 1;
    end
    fire_req = rst_n && imem_req_valid && imem_req_ready;
    fire_out = rst_n && out_valid && out_ready;
    rsp_now = imem_rsp_valid;
    a = imem_req_addr;
    @(posedge clk);
    if (!rst_n) begin
      exp_pc = RST; m_halt = 0; m_fault = 0;
    end else if (redirect_valid && !m_halt) begin
      if (redirect_pc[1:0] != 2'b00) begin m_halt = 1; m_fault = 1; end
      else exp_pc = redirect_pc;
    end else if (fire_out) begin
      exp_pc += 4;
      n_deliv++;
    end
    if (rsp_now) pend = 0;
    if (fire_req) begin
      pend = 1; pend_addr = a;
      wait_cnt = rnd ? int'($urandom_range(0, max_wait)) : max_wait;
    end
    @(negedge clk);
    if (pend && wait_cnt == 0) begin
      imem_rsp_valid = 1;
      imem_rsp_data = bad_data ? 32'hDEADBEEF : word(pend_addr);
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = $urandom;
      if (pend) wait_cnt--;
    end
  endtask

  task automatic do_reset();
    rst_n = 0; out_ready = 0; redirect_valid = 0; halt = 0; bad_data = 0; saw_dead = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic wait_ov(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!s_ov && n < 20);
    chk(tag, s_ov, 1);
  endtask

  initial begin
    logic [6:0] ovs;
    // zero-wait memory: words delivered in cycles 3 and 6
    do_reset();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_fault", fetch_fault, 0);
    max_wait = 0; rnd = 0; out_ready = 1;
    for (int t = 0; t < 7; t++) begin
      tick();
      ovs[t] = s_ov;
      if (t == 3) chk("first_pc", s_pc, 32'h8000_0000);
      if (t == 6) chk("second_inst", s_inst, 32'h00100073);
    end
    chk("out_valid_cycles", ovs, 7'b1001000);

    // decode stall in HOLD
    do_reset();
    wait_ov("stall_hold_reached");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", s_pc, 32'h8000_0000);
      chk("stall_inst", s_inst, 32'h00100093);
      chk("stall_req_valid", s_rv, 0);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    tick();
    chk("after_stall_req", s_rv, 1);
    chk("after_stall_addr", s_addr, 32'h8000_0004);

    // redirect during WAIT, stale response two cycles later
    do_reset();
    out_ready = 1; max_wait = 2; bad_data = 1;
    tick(); tick();
    redirect_valid = 1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 0;
    tick(); chk("wait_redir_t3", s_rv, 0);
    tick(); chk("wait_redir_t4", s_rv, 0);
    bad_data = 0;
    tick();
    chk("wait_redir_req", s_rv, 1);
    chk("wait_redir_addr", s_addr, 32'h8000_0100);
    wait_ov("wait_redir_deliver");
    chk("wait_redir_pc", s_pc, 32'h8000_0100);
    chk("no_deadbeef", saw_dead, 0);

    // redirect in the cycle the request for 8000_0004 is accepted
    do_reset();
    out_ready = 1; max_wait = 0;
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1; redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 0;
    chk("accept_redir_req", s_rv, 1);
    chk("accept_redir_addr", s_addr, 32'h8000_0004);
    wait_ov("accept_redir_deliver");
    chk("accept_redir_pc", s_pc, 32'h8000_0200);

    // misaligned redirect: sticky fault, permanently idle
    redirect_valid = 1; redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 0;
    tick();
    chk("fault_set", s_rv, 0);
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'($urandom);
      tick();
    end
    chk("fault_sticky", fetch_fault, 1);
    do_reset();
    chk("fault_cleared", fetch_fault, 0);

    // halt while a word is held: word still delivered, then nothing
    wait_ov("halt_hold_reached");
    halt = 1;
    tick();
    chk("halt_still_hold", s_ov, 1);
    out_ready = 1;
    tick();
    chk("halt_delivered_pc", s_pc, 32'h8000_0000);
    m_halt = 1;
    for (int i = 0; i < 4; i++) begin tick(); chk("halt_no_req", s_rv, 0); end
    halt = 0;
    for (int i = 0; i < 3; i++) begin tick(); chk("halted_no_req", s_rv, 0); end

    // reset mid-WAIT, stray response arrives in REQ
    do_reset();
    out_ready = 1; max_wait = 2; bad_data = 1;
    tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    chk("boot_no_req", s_rv, 0);
    tick();
    chk("stray_rsp_present", imem_rsp_valid, 0);
    bad_data = 0;
    wait_ov("mid_wait_reset_deliver");
    chk("mid_wait_reset_pc", s_pc, 32'h8000_0000);
    chk("mid_wait_reset_inst", s_inst, 32'h00100093);
    chk("mid_wait_no_deadbeef", saw_dead, 0);

    // random traffic: variable latency, backpressure, aligned redirects
    do_reset();
    rnd = 1; max_wait = 3; n_deliv = 0;
    for (int t = 0; t < 800; t++) begin
      imem_req_ready = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      redirect_valid = t > 2 && $urandom_range(0, 15) == 0;
      redirect_pc = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
      tick();
    end
    chk("random_progress", n_deliv > 50, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: holds the program counter, issues one word-aligned read at a time to instruction memory, and presents the fetched word and its PC to the decode stage over a valid/ready handshake. It sits directly upstream of decode. It accepts PC redirects from execute, and a halt request from decode's stop signal. It has at most one memory request outstanding.

## Interface
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset; bits [1:0] must be 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  read address; always equals the internal pc.
- imem_rsp_valid  in  1  read data valid. At most one per accepted request, arriving no earlier than the cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- out_valid  out  1  out_inst and out_pc are valid for decode.
- out_ready  in  1  decode consumes the word this cycle.
- out_inst  out  32  fetched instruction.
- out_pc  out  32  PC of out_inst.
- redirect_valid  in  1  next PC comes from redirect_pc.
- redirect_pc  in  32  redirect target.
- halt  in  1  stop issuing new fetches.
- fetch_fault  out  1  sticky flag: a misaligned redirect occurred.

## Operation
- States: BOOT, REQ, WAIT, HOLD, HALTED. Registers: pc, kill, out_inst, out_pc, fetch_fault.
- Reset (rst_n=0 at an edge) sets:
  - state=BOOT, pc=RESET_PC, kill=0, fetch_fault=0, out_inst=0, out_pc=0.
- Combinational outputs:
  - imem_req_valid = (state==REQ) & ~halt.
  - out_valid = (state==HOLD).
  - imem_req_addr = pc.
- BOOT: go to REQ unconditionally.
- REQ:
  - If halt=1: go to HALTED; no request is issued.
  - Else, on imem_req_ready: go to WAIT.
  - Otherwise stay in REQ; imem_req_valid and imem_req_addr stay stable until acceptance.
- WAIT, on imem_rsp_valid:
  - If kill=1: discard the data, clear kill, go to REQ.
  - Else: out_inst<=imem_rsp_data, out_pc<=pc, go to HOLD.
- HOLD:
  - On out_ready: pc<=pc+4 (modulo 2^32), go to REQ.
  - Otherwise hold out_inst and out_pc stable.
- HALTED: all outputs idle. Only reset exits this state.
- Redirect has priority over every other event in every state except BOOT and HALTED:
  - If redirect_pc[1:0]!=0: set fetch_fault=1 and go to HALTED; pc is unchanged. A response still in flight is ignored.
  - Else, always: pc<=redirect_pc.
  - In REQ: if the request is accepted in the same cycle, go to WAIT with kill=1; otherwise stay in REQ.
  - In WAIT: set kill=1. If imem_rsp_valid arrives in the same cycle, drop the data and go to REQ with kill=0.
  - In HOLD: drop the held word (even if out_ready=1 this cycle) and go to REQ. out_valid is 0 the next cycle.
- Halt during WAIT or HOLD has no effect until the FSM reaches REQ. A word already in HOLD is still delivered.
- There is no flow through from memory to decode: memory is never ready-coupled to decode.

## Timing
- With rst_n released before edge 0: BOOT→REQ at edge 1, so imem_req_valid=1 in cycle 1.
- With zero-wait memory (ready=1, response the cycle after acceptance):
  - Request accepted in cycle 1, response in cycle 2, out_valid=1 in cycle 3.
  - Peak throughput: one instruction per 3 cycles.
- Redirect to first request at the new PC: 1 cycle from REQ, WAIT (killed; after the response arrives), or HOLD.
- fetch_fault rises the cycle after a misaligned redirect and stays at 1 until reset.
- Reset mid-WAIT: any later response must be ignored. After reset, BOOT issues no request, and a stray imem_rsp_valid in REQ or BOOT is ignored.

## Test plan
- Reset release, ready=1, memory returns 32'h00100093 at 8000_0000 and 32'h00100073 at 8000_0004, out_ready=1 → out_valid in cycles 3 and 6. The PC sequence 8000_0000 then 8000_0004 is observed on out_pc with the matching words.
- out_ready=0 for 5 cycles while in HOLD → out_inst and out_pc stay stable and imem_req_valid stays 0. The next request (addr 8000_0004) is issued the cycle after out_ready=1.
- Redirect to 8000_0100 while in WAIT, response arriving 2 cycles later with 32'hDEADBEEF → word is never presented; next request addr=8000_0100.
- Redirect to 8000_0200 in the same cycle the request for 8000_0004 is accepted → response discarded; next out_pc=8000_0200.
- Redirect to 8000_0102 → fetch_fault=1 the next cycle, state HALTED, imem_req_valid=0 forever; cleared by rst_n=0.
- halt=1 while the word at 8000_0000 is in HOLD → the word is delivered on out_ready, then no further request is issued and imem_req_valid stays 0.
